// File: rtl/vend_pkg.sv
// Coin constants and encodings shared by the vending controller and the change dispenser.
package vend_pkg;

  localparam int unsigned Denom50 = 50;
  localparam int unsigned Denom10 = 10;
  localparam int unsigned Denom5  = 5;
  localparam int unsigned Denom1  = 1;

  typedef enum logic [1:0] {
    Coin1  = 2'd0,
    Coin5  = 2'd1,
    Coin10 = 2'd2,
    Coin50 = 2'd3
  } coin_sel_e;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StIssue,
    StFinish
  } cd_state_e;

  function automatic int unsigned coin_value(coin_sel_e sel);
    int unsigned val;
    unique case (sel)
      Coin50:  val = Denom50;
      Coin10:  val = Denom10;
      Coin5:   val = Denom5;
      default: val = Denom1;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/denom_picker.sv
// Greedy denomination choice: largest non-empty coin whose value fits in the remainder.
module denom_picker
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [3:0]       hopper_empty,
  output logic             found,
  output coin_sel_e        sel
);

  logic [31:0] rem_w;
  assign rem_w = 32'(remaining);

  always_comb begin
    found = 1'b1;
    sel   = Coin1;
    if (!hopper_empty[3] && (rem_w >= Denom50)) begin
      sel = Coin50;
    end else if (!hopper_empty[2] && (rem_w >= Denom10)) begin
      sel = Coin10;
    end else if (!hopper_empty[1] && (rem_w >= Denom5)) begin
      sel = Coin5;
    end else if (!hopper_empty[0] && (rem_w >= Denom1)) begin
      sel = Coin1;
    end else begin
      found = 1'b0;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout FSM: splits an amount into coins and offers them one at a time to the hopper.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [3:0]       hopper_empty,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remaining
);

  cd_state_e        state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  coin_sel_e        coin_sel_q, coin_sel_d;
  logic             err_flag_q, err_flag_d;

  logic             pick_found;
  coin_sel_e        pick_sel;

  denom_picker #(
    .AMT_W(AMT_W)
  ) u_denom_picker (
    .remaining   (remaining_q),
    .hopper_empty(hopper_empty),
    .found       (pick_found),
    .sel         (pick_sel)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_sel_d  = coin_sel_q;
    err_flag_d  = err_flag_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = amount;
          err_flag_d  = 1'b0;
          state_d     = StSelect;
        end
      end
      StSelect: begin
        if (remaining_q == '0) begin
          state_d = StFinish;
        end else if (pick_found) begin
          coin_sel_d = pick_sel;
          state_d    = StIssue;
        end else begin
          err_flag_d = 1'b1;
          state_d    = StFinish;
        end
      end
      StIssue: begin
        // Picker guarantees the coin value never exceeds the remainder.
        if (coin_ready) begin
          remaining_d = remaining_q - AMT_W'(coin_value(coin_sel_q));
          state_d     = StSelect;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      coin_sel_q  <= Coin1;
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_sel_q  <= coin_sel_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign coin_valid = (state_q == StIssue);
  assign coin_sel   = coin_sel_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFinish);
  assign err        = (state_q == StFinish) && err_flag_q;
  assign remaining  = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with hand-computed coin sequences and timing.
module tb_change_dispenser;

  localparam int unsigned AMT_W = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [3:0]       hopper_empty;
  logic             coin_ready;
  logic             coin_valid;
  logic [1:0]       coin_sel;
  logic             busy;
  logic             done;
  logic             err;
  logic [AMT_W-1:0] remaining;

  int errors = 0;
  int checks = 0;

  logic [1:0] coin_q[$];
  logic [1:0] exp_q[$];
  int         done_cyc;
  logic       err_seen;
  logic [7:0] rem_seen;

  change_dispenser #(
    .AMT_W(AMT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .amount      (amount),
    .hopper_empty(hopper_empty),
    .coin_ready  (coin_ready),
    .coin_valid  (coin_valid),
    .coin_sel    (coin_sel),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .remaining   (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sit 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for the edge E0; returns in the cycle after E0.
  task automatic start_txn(input logic [AMT_W-1:0] amt);
    start  = 1'b1;
    amount = amt;
    step();
    start  = 1'b0;
  endtask

  // Count edges after E0 until done; log every cycle with coin_valid high.
  task automatic collect(input int max_cyc);
    coin_q.delete();
    done_cyc = -1;
    err_seen = 1'b0;
    rem_seen = '0;
    for (int k = 1; k <= max_cyc; k++) begin
      step();
      if (coin_valid) coin_q.push_back(coin_sel);
      if (done) begin
        done_cyc = k;
        err_seen = err;
        rem_seen = remaining;
        break;
      end
    end
  endtask

  task automatic chk_coins(input string tag);
    chk({tag, "_ncoins"}, 32'(coin_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < coin_q.size(); i++) begin
      chk($sformatf("%s_coin%0d", tag, i), 32'(coin_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    amount       = '0;
    hopper_empty = 4'b0000;
    coin_ready   = 1'b1;
    step();
    step();
    chk("rst_coin_valid", 32'(coin_valid), 32'd0);
    chk("rst_coin_sel", 32'(coin_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    reset = 1'b1;
    step();

    // 67 = 50 + 10 + 5 + 1 + 1
    start_txn(8'd67);
    chk("t67_busy_e0", 32'(busy), 32'd1);
    chk("t67_valid_e0", 32'(coin_valid), 32'd0);
    collect(30);
    exp_q = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    chk_coins("t67");
    chk("t67_done_cyc", 32'(done_cyc), 32'd11);
    chk("t67_err", 32'(err_seen), 32'd0);
    chk("t67_rem", 32'(rem_seen), 32'd0);
    step();
    chk("t67_done_pulse", 32'(done), 32'd0);
    chk("t67_busy_end", 32'(busy), 32'd0);

    start_txn(8'd0);
    collect(10);
    exp_q.delete();
    chk_coins("t0");
    chk("t0_done_cyc", 32'(done_cyc), 32'd1);
    chk("t0_err", 32'(err_seen), 32'd0);
    step();
    chk("t0_done_pulse", 32'(done), 32'd0);
    chk("t0_busy_end", 32'(busy), 32'd0);

    // 10s empty: 30 paid as six 5s
    hopper_empty = 4'b0100;
    start_txn(8'd30);
    collect(40);
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    chk_coins("t30");
    chk("t30_done_cyc", 32'(done_cyc), 32'd13);
    chk("t30_err", 32'(err_seen), 32'd0);
    chk("t30_rem", 32'(rem_seen), 32'd0);
    step();

    // 1s empty: 3 cannot be paid
    hopper_empty = 4'b0001;
    start_txn(8'd3);
    collect(10);
    exp_q.delete();
    chk_coins("t3");
    chk("t3_done_cyc", 32'(done_cyc), 32'd1);
    chk("t3_err", 32'(err_seen), 32'd1);
    chk("t3_rem", 32'(rem_seen), 32'd3);
    for (int i = 0; i < 4; i++) step();
    chk("t3_rem_hold", 32'(remaining), 32'd3);
    chk("t3_err_idle", 32'(err), 32'd0);
    chk("t3_busy_idle", 32'(busy), 32'd0);

    // Stall the first coin of 15 for four cycles; a start during busy is ignored
    hopper_empty = 4'b0000;
    coin_ready   = 1'b0;
    start_txn(8'd15);
    chk("t15_rem_e0", 32'(remaining), 32'd15);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("t15_stall_valid%0d", i), 32'(coin_valid), 32'd1);
      chk($sformatf("t15_stall_sel%0d", i), 32'(coin_sel), 32'd2);
      chk($sformatf("t15_stall_rem%0d", i), 32'(remaining), 32'd15);
      if (i == 2) begin
        start  = 1'b1;
        amount = 8'd99;
      end else begin
        start = 1'b0;
      end
    end
    coin_ready = 1'b1;
    step();
    chk("t15_rem_after10", 32'(remaining), 32'd5);
    chk("t15_valid_select", 32'(coin_valid), 32'd0);
    collect(10);
    exp_q = '{2'd1};
    chk_coins("t15");
    chk("t15_done_cyc", 32'(done_cyc), 32'd3);
    chk("t15_err", 32'(err_seen), 32'd0);
    chk("t15_rem", 32'(rem_seen), 32'd0);
    step();
    chk("t15_busy_end", 32'(busy), 32'd0);

    // Reset in the middle of an offer
    coin_ready = 1'b0;
    start_txn(8'd67);
    step();
    chk("trst_valid_before", 32'(coin_valid), 32'd1);
    reset = 1'b0;
    step();
    chk("trst_valid", 32'(coin_valid), 32'd0);
    chk("trst_busy", 32'(busy), 32'd0);
    chk("trst_rem", 32'(remaining), 32'd0);
    chk("trst_done", 32'(done), 32'd0);
    reset      = 1'b1;
    coin_ready = 1'b1;
    step();
    start_txn(8'd6);
    collect(20);
    exp_q = '{2'd1, 2'd0};
    chk_coins("t6");
    chk("t6_done_cyc", 32'(done_cyc), 32'd5);
    chk("t6_err", 32'(err_seen), 32'd0);
    chk("t6_rem", 32'(rem_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
